// File: rtl/cache_ctrl.sv
// -----------------------------------------------------------------------------
// cache_ctrl
//   Sequencer in front of a 128-byte direct-mapped cache
//   (tag = addr[15:7], index = addr[6:0]). Takes one CPU byte access at a time.
//   Reads look up the cache and fill the line from memory on a miss.
//   Writes go to the cache and through to memory.
//   Completion is a one-cycle cpu_ready pulse. cpu_err flags a memory timeout.
//
// Parameters
//   TIMEOUT  max mem_req cycles to wait for mem_ack before aborting
//   TW       timeout counter width (2**TW > TIMEOUT)
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   cpu_req/we/addr/wdata    CPU request, sampled only in IDLE
//   cpu_rdata/ready/err      completion pulse with read data and error flag
//   busy                     high in every state except IDLE
//   cache_addr/we/wdata      cache array access (cache_we also updates the tag)
//   cache_rdata, cache_hit   cache read data and combinational tag match
//   mem_req/we/addr/wdata    memory request, held until ack or timeout
//   mem_rdata, mem_ack       memory read data, one-cycle acknowledge
//
// Optional feature (macro CACHE_CTRL_STATS_EN)
//   hit_cnt, miss_cnt        saturating lookup hit/miss counters
//   stats_clr                synchronous clear, wins over increment
// -----------------------------------------------------------------------------
module cache_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int TW      = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_ready,
   output logic        cpu_err,
   output logic        busy,
   output logic [15:0] cache_addr,
   output logic        cache_we,
   output logic [7:0]  cache_wdata,
   input  logic [7:0]  cache_rdata,
   input  logic        cache_hit,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack
`ifdef CACHE_CTRL_STATS_EN
   ,
   output logic [15:0] hit_cnt,
   output logic [15:0] miss_cnt,
   input  logic        stats_clr
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MEM_RD,
      FILL,
      WRITE,
      DONE
   } state_t;

   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

   state_t        state;
   logic [15:0]   addr_q;
   logic [7:0]    data_q;   // write data, or the byte fetched on a miss
   logic [TW-1:0] tcnt;

   // Timeout counter step: saturates at TIMEOUT.
   function automatic logic [TW-1:0] tcnt_inc(input logic [TW-1:0] c);
      return (c >= TMAX) ? c : c + 1'b1;
   endfunction

   // The cache and memory always see the captured address; data paths share
   // one byte register (write data or fill data, never both at once).
   assign cache_addr  = addr_q;
   assign mem_addr    = addr_q;
   assign cache_wdata = data_q;
   assign mem_wdata   = data_q;

   // Outputs are registered: each is set on the transition into the state
   // that asserts it, and the one-cycle strobes default back to 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         tcnt      <= '0;
         cpu_rdata <= '0;
         cpu_ready <= 1'b0;
         cpu_err   <= 1'b0;
         busy      <= 1'b0;
         cache_we  <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
      end else begin
         cpu_ready <= 1'b0;
         cpu_err   <= 1'b0;
         cpu_rdata <= '0;
         cache_we  <= 1'b0;
         if (mem_req) tcnt <= tcnt_inc(tcnt);

         case (state)
            IDLE: begin
               if (cpu_req) begin
                  addr_q <= cpu_addr;
                  data_q <= cpu_wdata;
                  busy   <= 1'b1;
                  if (cpu_we) begin
                     // Cache write happens in the first WRITE cycle only.
                     state    <= WRITE;
                     cache_we <= 1'b1;
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b1;
                     tcnt     <= '0;
                  end else begin
                     state <= LOOKUP;
                  end
               end
            end

            LOOKUP: begin
               if (cache_hit) begin
                  state     <= DONE;
                  cpu_ready <= 1'b1;
                  cpu_rdata <= cache_rdata;
               end else begin
                  state   <= MEM_RD;
                  mem_req <= 1'b1;
                  mem_we  <= 1'b0;
                  tcnt    <= '0;
               end
            end

            MEM_RD: begin
               // An ack on the terminal-count cycle still completes normally.
               if (mem_ack) begin
                  data_q   <= mem_rdata;
                  mem_req  <= 1'b0;
                  cache_we <= 1'b1;
                  state    <= FILL;
               end else if (tcnt_inc(tcnt) == TMAX) begin
                  mem_req   <= 1'b0;
                  state     <= DONE;
                  cpu_ready <= 1'b1;
                  cpu_err   <= 1'b1;
               end
            end

            FILL: begin
               state     <= DONE;
               cpu_ready <= 1'b1;
               cpu_rdata <= data_q;
            end

            WRITE: begin
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  state     <= DONE;
                  cpu_ready <= 1'b1;
               end else if (tcnt_inc(tcnt) == TMAX) begin
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  state     <= DONE;
                  cpu_ready <= 1'b1;
                  cpu_err   <= 1'b1;
               end
            end

            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
            end
         endcase
      end
   end

`ifdef CACHE_CTRL_STATS_EN
   function automatic logic [15:0] sat16_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (stats_clr) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (state == LOOKUP) begin
         if (cache_hit) hit_cnt  <= sat16_inc(hit_cnt);
         else           miss_cnt <= sat16_inc(miss_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl
//   Bench for cache_ctrl. Provides a behavioural cache array and a memory
//   responder with a programmable wait count, and predicts every access
//   (latency, data, error, memory/cache activity) from a transaction-level
//   reference model of the cache contents and memory.
// -----------------------------------------------------------------------------
module tb_cache_ctrl;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_ready, cpu_err, busy;
   logic [15:0] cache_addr;
   logic        cache_we;
   logic [7:0]  cache_wdata;
   logic [7:0]  cache_rdata;
   logic        cache_hit;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;
`ifdef CACHE_CTRL_STATS_EN
   logic [15:0] hit_cnt, miss_cnt;
   logic        stats_clr;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   cache_ctrl #(.TIMEOUT(TIMEOUT), .TW(5)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err), .busy(busy),
      .cache_addr(cache_addr), .cache_we(cache_we), .cache_wdata(cache_wdata),
      .cache_rdata(cache_rdata), .cache_hit(cache_hit),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_CTRL_STATS_EN
      , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .stats_clr(stats_clr)
`endif
   );

   // ---------------- environment: cache array ----------------
   logic       cval [128];
   logic [8:0] ctag [128];
   logic [7:0] cdat [128];

   assign cache_hit   = cval[cache_addr[6:0]] && (ctag[cache_addr[6:0]] == cache_addr[15:7]);
   assign cache_rdata = cdat[cache_addr[6:0]];

   always @(posedge clk) begin
      if (cache_we) begin
         cval[cache_addr[6:0]] <= 1'b1;
         ctag[cache_addr[6:0]] <= cache_addr[15:7];
         cdat[cache_addr[6:0]] <= cache_wdata;
      end
   end

   // ---------------- environment: memory responder ----------------
   logic [7:0] mem [65536];
   int resp_waits = 0;
   int rcnt = 0;
   bit junk_en = 1'b0;

   always @(negedge clk) begin
      if (mem_req && !rst) begin
         if (rcnt == resp_waits) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
            if (mem_we) mem[mem_addr] = mem_wdata;
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
         end
         rcnt++;
      end else begin
         rcnt      = 0;
         mem_ack   = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
         mem_rdata = 8'($urandom);
      end
   end

   // ---------------- reference model ----------------
   bit         rval [128];
   logic [8:0] rtag [128];
   logic [7:0] rdat [128];
   logic [7:0] rmem [65536];
   int exp_hits = 0;
   int exp_miss = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One CPU access: predict from the model, drive, observe, compare.
   task automatic access(input bit we, input logic [15:0] a, input logic [7:0] wd,
                         input int waits, input string tag);
      logic [6:0]  idx;
      bit          hit, to, exp_err;
      int          exp_lat, exp_req, exp_cwe;
      logic [7:0]  exp_rd, exp_cwd;
      int          lat, nreq, ncwe, side_bad, busy_bad;
      logic [15:0] cwa;
      logic [7:0]  cwd, got_rd;
      logic        got_err;

      idx = a[6:0];
      hit = rval[idx] && (rtag[idx] == a[15:7]);
      to  = (waits >= TIMEOUT);
      exp_cwd = 8'h00;
      if (we) begin
         exp_lat = to ? 1 + TIMEOUT : 2 + waits;
         exp_req = to ? TIMEOUT : waits + 1;
         exp_cwe = 1; exp_cwd = wd; exp_rd = 8'h00; exp_err = to;
         rval[idx] = 1'b1; rtag[idx] = a[15:7]; rdat[idx] = wd;
         if (!to) rmem[a] = wd;
      end else if (hit) begin
         exp_lat = 2; exp_req = 0; exp_cwe = 0; exp_rd = rdat[idx]; exp_err = 1'b0;
         exp_hits++;
      end else begin
         exp_miss++;
         if (to) begin
            exp_lat = 2 + TIMEOUT; exp_req = TIMEOUT; exp_cwe = 0;
            exp_rd = 8'h00; exp_err = 1'b1;
         end else begin
            exp_lat = 4 + waits; exp_req = waits + 1; exp_cwe = 1;
            exp_cwd = rmem[a]; exp_rd = rmem[a]; exp_err = 1'b0;
            rval[idx] = 1'b1; rtag[idx] = a[15:7]; rdat[idx] = rmem[a];
         end
      end

      resp_waits = waits;
      cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
      lat = 99; nreq = 0; ncwe = 0; side_bad = 0; busy_bad = 0;
      cwa = 16'h0; cwd = 8'h0; got_rd = 8'h0; got_err = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (junk_en) begin
            cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
         end else begin
            cpu_req = 1'b0;
         end
         if (!busy) busy_bad++;
         if (cache_addr !== a) side_bad++;
         if (mem_req) begin
            nreq++;
            if (mem_we !== we || mem_addr !== a || (we && mem_wdata !== wd)) side_bad++;
         end
         if (cache_we) begin
            ncwe++; cwa = cache_addr; cwd = cache_wdata;
         end
         if (cpu_ready) begin
            lat = n; got_rd = cpu_rdata; got_err = cpu_err;
            break;
         end
      end
      cpu_req = 1'b0;

      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_rdata"}, got_rd, exp_rd);
      chk({tag, "_err"}, got_err, exp_err);
      chk({tag, "_memreq_cycles"}, nreq, exp_req);
      chk({tag, "_cache_we_cycles"}, ncwe, exp_cwe);
      if (exp_cwe != 0) begin
         chk({tag, "_fill_addr"}, cwa, a);
         chk({tag, "_fill_data"}, cwd, exp_cwd);
      end
      chk({tag, "_bus_fields"}, side_bad, 0);
      chk({tag, "_busy_held"}, busy_bad, 0);
      @(negedge clk);
      chk({tag, "_back_idle"}, {cpu_ready, busy, mem_req, cache_we}, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [15:0] pool [8];

   initial begin
      int act;
      logic [15:0] ra;
      int r, w;

      pool = '{16'h1234, 16'h0081, 16'h9234, 16'h0001, 16'h8001, 16'hFFFF, 16'h007F, 16'h4000};
      for (int i = 0; i < 128; i++) begin
         cval[i] = 1'b0; ctag[i] = '0; cdat[i] = '0;
         rval[i] = 1'b0; rtag[i] = '0; rdat[i] = '0;
      end
      for (int i = 0; i < 65536; i++) begin
         mem[i] = 8'($urandom);
         rmem[i] = mem[i];
      end
      mem[16'h1234] = 8'hA5; rmem[16'h1234] = 8'hA5;
      mem_ack = 1'b0; mem_rdata = 8'h00;
`ifdef CACHE_CTRL_STATS_EN
      stats_clr = 1'b0;
`endif

      // Reset with cpu_req toggling: nothing must happen.
      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_wdata = 8'h55;
      act = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cpu_req = ~cpu_req;
         act += int'(|{cpu_rdata, cpu_ready, cpu_err, busy, cache_addr, cache_we,
                       cache_wdata, mem_req, mem_we, mem_addr, mem_wdata});
      end
      chk("reset_outputs_zero", act, 0);
      cpu_req = 1'b0;
      rst = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("idle_after_reset", {cpu_ready, busy, mem_req, cache_we, mem_we}, 0);
      chk("idle_addr_zero", cache_addr, 16'h0000);
`ifdef CACHE_CTRL_STATS_EN
      chk("stats_reset_hit", hit_cnt, 0);
      chk("stats_reset_miss", miss_cnt, 0);
`endif

      // Directed accesses.
      access(1'b0, 16'h1234, 8'h00, 3, "rd_miss_1234");
      access(1'b0, 16'h1234, 8'h00, 0, "rd_hit_1234");
      access(1'b1, 16'h0081, 8'h3C, 0, "wr_0081");
      access(1'b0, 16'h0081, 8'h00, 0, "rd_hit_0081");
      access(1'b0, 16'h4000, 8'h00, 1000, "rd_timeout");
      access(1'b0, 16'h4000, 8'h00, 15, "rd_ack_terminal");
      access(1'b1, 16'h5005, 8'h77, 1000, "wr_timeout");
      access(1'b0, 16'h5005, 8'h00, 0, "rd_after_wr_timeout");
      access(1'b1, 16'h6006, 8'h19, 15, "wr_ack_terminal");

      // Reset during MEM_RD: mem_req must drop at once, no completion.
      resp_waits = 1000;
      cpu_we = 1'b0; cpu_addr = 16'h7777; cpu_req = 1'b1;
      @(negedge clk); cpu_req = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("rstmid_req_active", mem_req, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("rstmid_req_dropped", {mem_req, busy, cpu_ready, cache_we}, 0);
      @(negedge clk);
      rst = 1'b0;
      exp_hits = 0; exp_miss = 0;
      act = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         act += int'(cpu_ready | cache_we | busy | mem_req);
      end
      chk("rstmid_no_activity", act, 0);
      access(1'b0, 16'h7777, 8'h00, 2, "rd_after_rstmid");

      // Randomized traffic with ignored cpu_req/mem_ack noise.
      junk_en = 1'b1;
      for (int i = 0; i < 60; i++) begin
         ra = pool[$urandom_range(0, 7)];
         r  = $urandom_range(0, 9);
         w  = (r < 6) ? r : (r == 6) ? 14 : (r == 7) ? 15 : (r == 8) ? 16 : 40;
         access(($urandom_range(0, 3) == 0), ra, 8'($urandom), w, "rand");
      end
      junk_en = 1'b0;

`ifdef CACHE_CTRL_STATS_EN
      chk("stats_hits_total", hit_cnt, exp_hits);
      chk("stats_miss_total", miss_cnt, exp_miss);
      stats_clr = 1'b1;
      @(negedge clk);
      stats_clr = 1'b0;
      chk("stats_clr_hit", hit_cnt, 0);
      chk("stats_clr_miss", miss_cnt, 0);
      access(1'b0, 16'hABCD, 8'h00, 2, "stats_miss");
      access(1'b0, 16'hABCD, 8'h00, 0, "stats_hit");
      chk("stats_one_hit", hit_cnt, 1);
      chk("stats_one_miss", miss_cnt, 1);
      stats_clr = 1'b1;
      @(negedge clk);
      stats_clr = 1'b0;
      chk("stats_clr2_hit", hit_cnt, 0);
      chk("stats_clr2_miss", miss_cnt, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
